sqrt_req_arbiter: RTL and testbench
===================================

// Module: sqrt_req_arbiter
// PURPOSE
//  Shares one eightBSqrt unit among NUM_REQ requesters using round-robin arbitration.
//  Latches the winner's operand and drives the unit's St/N handshake.
//  Runs the full St/done cycle: hold St until done=1, capture sqrt, drop St, wait for done=0.
//  Returns the result to the requester as a one-cycle tagged response.
// PARAMETERS
//  NUM_REQ      4   number of requesters (2..8)
//  DATA_W       8   operand width, matches sqrt unit N
//  RES_W        4   result width, matches sqrt unit sqrt
//  TIMEOUT_CYC  64  watchdog limit in cycles per handshake phase (SQRT_ARB_TIMEOUT_EN only)
// PORTS
//  clk          in   1               system clock, rising edge
//  rst          in   1               async reset, active-high
//  req          in   NUM_REQ         level request per requester
//  req_data     in   NUM_REQ*DATA_W  operands; requester i at [i*DATA_W +: DATA_W]
//  gnt          out  NUM_REQ         one-hot, one-cycle pulse: operand captured
//  rsp_valid    out  1               one-cycle pulse: result available
//  rsp_id       out  clog2(NUM_REQ)  index of the requester that owns the result
//  rsp_sqrt     out  RES_W           result
//  busy         out  1               1 whenever state != IDLE
//  sq_st        out  1               to sqrt unit St
//  sq_n         out  DATA_W          to sqrt unit N
//  sq_done      in   1               from sqrt unit done
//  sq_sqrt      in   RES_W           from sqrt unit sqrt
//  timeout_err  out  1               sticky watchdog flag (SQRT_ARB_TIMEOUT_EN only)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; rr_ptr=0; all outputs 0.
//   The sqrt unit must be reset by the same event; no in-flight result is returned.
//  FSM states: IDLE -> ISSUE -> RELEASE -> IDLE.
//  IDLE:
//   - If req!=0: winner = first set bit searching from rr_ptr upward, with wrap-around.
//   - Latch id and req_data slice; gnt[id]=1 for that cycle; go to ISSUE.
//   - If req==0: remain in IDLE.
//  ISSUE:
//   - sq_st=1; sq_n=latched operand, held stable.
//   - When sq_done=1: capture sq_sqrt; go to RELEASE.
//  RELEASE:
//   - sq_st=0.
//   - When sq_done=0: rsp_valid=1, rsp_id=id, rsp_sqrt=captured, for exactly 1 cycle.
//   - rr_ptr=(id+1) mod NUM_REQ; go to IDLE.
//  Throughput / latency:
//   - gnt is registered from IDLE; sq_st rises the cycle after gnt.
//   - Next arbitration occurs the cycle after rsp_valid.
//   - At most one operation is in flight.
//  Request rules:
//   - A requester drops req the cycle after its gnt.
//   - A req still high when the FSM returns to IDLE is treated as a new request.
//   - req changes during ISSUE/RELEASE are ignored.
//  Fairness: the previous winner has the lowest priority on the next arbitration.
//   Simultaneous requests resolve by rr_ptr order.
//  rsp_sqrt and rsp_id hold their last values when rsp_valid=0.
//  sq_n holds the last operand in IDLE.
// CONFIGURATION
//  SQRT_ARB_TIMEOUT_EN defined:
//   - Per-phase cycle counter, cleared on every state entry.
//   - ISSUE timeout (counter reaches TIMEOUT_CYC without sq_done=1):
//     rsp_valid pulse with rsp_sqrt=0; timeout_err=1; go to RELEASE.
//   - RELEASE timeout (sq_done stuck high): go straight to IDLE; timeout_err=1.
//   - timeout_err is sticky until rst.
//  SQRT_ARB_TIMEOUT_EN undefined:
//   - No counter and no timeout_err port; the FSM waits on sq_done indefinitely.
// TESTING
//  1 Single request: req=4'b0001, data0=0x90 -> gnt[0] pulse; rsp_id=0, rsp_sqrt=0xC.
//  2 Simultaneous requests: req=4'b1111 held, data = 0x00/0x10/0x51/0xFF
//    -> grant order 0,1,2,3; results 0x0,0x4,0x9,0xF.
//  3 Fairness: req0 held continuously, req2 pulsed once after gnt[0]
//    -> next grant is 2, then 0.
//  4 Protocol check: sq_st stays high until sq_done=1.
//    sq_n is stable throughout ISSUE; rsp_valid only appears after sq_done=0.
//  5 Reset mid-op: assert rst in ISSUE -> sq_st=0, busy=0, rsp_valid=0 immediately.
//    rr_ptr=0 afterwards.
//  6 (SQRT_ARB_TIMEOUT_EN) Hold sq_done=0 for 64 cycles
//    -> rsp_valid with rsp_sqrt=0; timeout_err=1 and stays set until rst.

Source files
------------

// File: rtl/sqrt_req_arbiter.sv
// -----------------------------------------------------------------------------
// sqrt_req_arbiter
//
// Shares one eightBSqrt unit among NUM_REQ requesters. A round-robin arbiter
// picks a winner in IDLE, the winner's operand is latched and presented on
// sq_n, and the unit's St/done handshake is run to completion before the
// result goes back to the requester as a one-cycle tagged response.
//
// Optional feature macro: SQRT_ARB_TIMEOUT_EN
//   When defined, a per-phase watchdog aborts a stuck ISSUE (response with
//   result 0) or a stuck RELEASE (straight back to IDLE). It also raises the
//   sticky timeout_err output. When undefined there is no counter and no
//   timeout_err port.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   req           level request per requester
//   req_data      operands; requester i at [i*DATA_W +: DATA_W]
//   gnt           one-hot, one-cycle pulse: operand captured
//   rsp_valid     one-cycle pulse: rsp_id / rsp_sqrt carry a result
//   rsp_id        requester that owns the result (held between pulses)
//   rsp_sqrt      result (held between pulses)
//   busy          1 whenever the FSM is not in IDLE
//   sq_st, sq_n   start and operand to the sqrt unit
//   sq_done       done from the sqrt unit
//   sq_sqrt       result from the sqrt unit
//   dbg_state     current FSM state (0=IDLE, 1=ISSUE, 2=RELEASE)
//   timeout_err   sticky watchdog flag (SQRT_ARB_TIMEOUT_EN only)
//
// Handshake with the sqrt unit (four-phase): sq_st rises and sq_n is held
// stable until sq_done=1. sq_sqrt is captured on that cycle and sq_st drops.
// The transaction is finished only once sq_done has returned to 0. Only then
// is rsp_valid pulsed and the arbiter re-armed, so at most one operation is
// ever in flight.
// -----------------------------------------------------------------------------
module sqrt_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int RES_W       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic [RES_W-1:0]            rsp_sqrt,
  output logic                        busy,
  output logic                        sq_st,
  output logic [DATA_W-1:0]           sq_n,
  input  logic                        sq_done,
  input  logic [RES_W-1:0]            sq_sqrt,
  output logic [1:0]                  dbg_state
`ifdef SQRT_ARB_TIMEOUT_EN
  ,
  output logic                        timeout_err
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_operand;
  logic [RES_W-1:0]    r_result;
  logic [NUM_REQ-1:0]  r_gnt;
  logic                r_rsp_valid;
  logic [ID_W-1:0]     r_rsp_id;
  logic [RES_W-1:0]    r_rsp_sqrt;
  logic                r_sq_st;

  logic                w_win_valid;
  logic [ID_W-1:0]     w_win_id;
  logic [ID_W:0]       w_sum;
  logic [ID_W-1:0]     w_idx;
  logic [ID_W-1:0]     w_ptr_next;
  logic                w_done_seen;
  logic                w_skip_rsp;
  logic                w_cnt_hit;

`ifdef SQRT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]    r_cnt;
  logic                r_timed_out;
  logic                r_timeout_err;
`endif

  // Only accept done while St is actually asserted, so a slow-falling done
  // from the previous operation can never be mistaken for a new result.
  assign w_done_seen = sq_done && r_sq_st;

  // Previous winner becomes lowest priority on the next arbitration.
  assign w_ptr_next = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + ID_W'(1);

  always_comb begin
    w_next_state = r_state;
    w_win_valid  = 1'b0;
    w_win_id     = '0;
    w_sum        = '0;
    w_idx        = '0;
    w_skip_rsp   = 1'b0;
    w_cnt_hit    = 1'b0;
`ifdef SQRT_ARB_TIMEOUT_EN
    w_skip_rsp   = r_timed_out;
    w_cnt_hit    = (r_state != S_IDLE) && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
`endif

    // Rotating search from rr_ptr upward with wrap-around; first hit wins.
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_rr_ptr} + (ID_W + 1)'(i);
      if (w_sum >= (ID_W + 1)'(NUM_REQ)) begin
        w_sum = w_sum - (ID_W + 1)'(NUM_REQ);
      end
      w_idx = w_sum[ID_W-1:0];
      if (!w_win_valid && req[w_idx]) begin
        w_win_valid = 1'b1;
        w_win_id    = w_idx;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (w_win_valid) w_next_state = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_done_seen)    w_next_state = S_RELEASE;
        else if (w_cnt_hit) w_next_state = S_RELEASE;
      end
      S_RELEASE: begin
        if (!sq_done)       w_next_state = S_IDLE;
        else if (w_cnt_hit) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_operand   <= '0;
      r_result    <= '0;
      r_gnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sqrt  <= '0;
      r_sq_st     <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_gnt       <= '0;
      r_rsp_valid <= 1'b0;
      // St is registered so it rises one cycle after gnt and drops on the
      // same edge that leaves ISSUE.
      r_sq_st     <= (r_state == S_ISSUE) && (w_next_state == S_ISSUE);
      case (r_state)
        S_IDLE: begin
          if (w_win_valid) begin
            r_id            <= w_win_id;
            r_operand       <= req_data[w_win_id*DATA_W +: DATA_W];
            r_gnt[w_win_id] <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (w_done_seen) begin
            r_result <= sq_sqrt;
          end else if (w_cnt_hit) begin
            // Aborted operation still gets a response, with a zero result.
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_sqrt  <= '0;
          end
        end
        S_RELEASE: begin
          if (!sq_done) begin
            r_rr_ptr <= w_ptr_next;
            if (!w_skip_rsp) begin
              r_rsp_valid <= 1'b1;
              r_rsp_id    <= r_id;
              r_rsp_sqrt  <= r_result;
            end
          end else if (w_cnt_hit) begin
            r_rr_ptr <= w_ptr_next;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SQRT_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_timed_out   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      // Counter restarts on every state entry and idles at zero in IDLE.
      if ((w_next_state != r_state) || (r_state == S_IDLE)) begin
        r_cnt <= '0;
      end else if (!w_cnt_hit) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if ((r_state == S_ISSUE) && !w_done_seen && w_cnt_hit) begin
        r_timed_out   <= 1'b1;
        r_timeout_err <= 1'b1;
      end
      if ((r_state == S_RELEASE) && sq_done && w_cnt_hit) begin
        r_timeout_err <= 1'b1;
      end
      // The response of an aborted operation was already sent.
      if ((r_state == S_RELEASE) && (w_next_state == S_IDLE)) begin
        r_timed_out <= 1'b0;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`endif

  assign gnt       = r_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_sqrt  = r_rsp_sqrt;
  assign busy      = (r_state != S_IDLE);
  assign sq_st     = r_sq_st;
  assign sq_n      = r_operand;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sqrt_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sqrt_req_arbiter
//
// Bench for sqrt_req_arbiter. A behavioural sqrt unit answers St with a random
// latency. A reference model predicts each grant from the round-robin rule
// (previous winner lowest priority) and each response from integer square
// root arithmetic. Directed scenarios cover single request, simultaneous
// requests, fairness, reset mid-operation and (with SQRT_ARB_TIMEOUT_EN) the
// watchdog, followed by a randomized traffic phase.
// -----------------------------------------------------------------------------
module tb_sqrt_req_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int RW = 4;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [RW-1:0]   rsp_sqrt;
  logic            busy;
  logic            sq_st;
  logic [DW-1:0]   sq_n;
  logic            sq_done;
  logic [RW-1:0]   sq_sqrt;
  logic [1:0]      dbg_state;
`ifdef SQRT_ARB_TIMEOUT_EN
  logic            timeout_err;
`endif

  always #5 clk = ~clk;

  sqrt_req_arbiter #(.NUM_REQ(N), .DATA_W(DW), .RES_W(RW), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sqrt(rsp_sqrt), .busy(busy),
    .sq_st(sq_st), .sq_n(sq_n), .sq_done(sq_done), .sq_sqrt(sq_sqrt),
    .dbg_state(dbg_state)
`ifdef SQRT_ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // ---------------- reference model / scoreboard ----------------
  logic [5:0]  exp_q[$];   // {id[1:0], sqrt[3:0]}
  int          gnt_log[$];
  logic [3:0]  rsp_log[$];
  int          rsp_cnt = 0;
  int          m_ptr;
  logic [DW-1:0] m_op;
  bit          st_due, prev_st, stall, rand_mode;
  logic [N-1:0] auto_drop;
  int          dly = 0;

  task automatic monitor();
    logic [5:0] e;
    int w;
    if (st_due) check("st_after_gnt", sq_st, 1);
    st_due = 0;
    if (gnt !== '0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
      check("gnt_onehot", gnt, (w < 0) ? 0 : (1 << w));
      check("gnt_while_busy", exp_q.size(), 0);
      if (w >= 0) begin
        m_op = req_data[w*DW +: DW];
        exp_q.push_back({2'(w), stall ? 4'h0 : 4'(isqrt(int'(m_op)))});
        gnt_log.push_back(w);
        m_ptr = (w + 1) % N;
      end
      st_due = 1;
    end
    if (sq_st) check("sq_n_stable", sq_n, m_op);
    if (prev_st && !sq_st && !stall) check("st_until_done", sq_done, 1);
    prev_st = sq_st;
    if (rsp_valid) begin
      check("rsp_after_done_low", sq_done, 0);
      if (exp_q.size() == 0) begin
        check("rsp_spurious", rsp_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", rsp_id, e[5:4]);
        check("rsp_sqrt", rsp_sqrt, e[3:0]);
      end
      rsp_log.push_back(rsp_sqrt);
      rsp_cnt++;
    end
  endtask

  // Behavioural sqrt unit: random latency on both handshake edges.
  task automatic sqrt_model();
    if (sq_st && !sq_done) begin
      if (!stall) begin
        if (dly == 0) begin
          sq_done = 1'b1;
          sq_sqrt = 4'(isqrt(int'(sq_n)));
          dly = $urandom_range(0, 3);
        end else dly--;
      end
    end else if (!sq_st && sq_done) begin
      if (dly == 0) begin
        sq_done = 1'b0;
        sq_sqrt = 4'($urandom_range(0, 15));
        dly = $urandom_range(0, 5);
      end else dly--;
    end
  endtask

  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      if (gnt[i] && auto_drop[i]) begin
        req[i] = 1'b0;
      end else if (rand_mode && !req[i] && $urandom_range(0, 3) == 0) begin
        req[i] = 1'b1;
        req_data[i*DW +: DW] = 8'($urandom_range(0, 255));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    sqrt_model();
    drive_req();
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int start = rsp_cnt;
    for (int c = 0; c < budget && rsp_cnt < start + n; c++) tick();
    check("rsp_count", rsp_cnt - start, n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    sq_done = 1'b0;
    sq_sqrt = '0;
    stall = 0;
    rand_mode = 0;
    auto_drop = '1;
    exp_q.delete();
    gnt_log.delete();
    rsp_log.delete();
    m_ptr = 0;
    prev_st = 0;
    st_due = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int         exp_ord[4] = '{0, 1, 2, 3};
  logic [3:0] exp_res[4] = '{4'h0, 4'h4, 4'h9, 4'hF};

  initial begin
    req_data = '0;
    do_reset();

    // Reset state
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_sqrt", rsp_sqrt, 0);
    check("rst_busy", busy, 0);
    check("rst_sq_st", sq_st, 0);
    check("rst_sq_n", sq_n, 0);
    check("rst_state", dbg_state, 0);

    // 1: single request
    req_data[7:0] = 8'h90;
    req = 4'b0001;
    wait_rsp(1, 200);
    check("t1_gnt_id", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);
    check("t1_sqrt", (rsp_log.size() > 0) ? rsp_log[0] : 4'hx, 4'hC);

    // 2: simultaneous requests from reset pointer
    do_reset();
    req_data = {8'hFF, 8'h51, 8'h10, 8'h00};
    req = 4'b1111;
    wait_rsp(4, 400);
    for (int i = 0; i < 4; i++) begin
      check("t2_order", (gnt_log.size() > i) ? gnt_log[i] : -1, exp_ord[i]);
      check("t2_result", (rsp_log.size() > i) ? rsp_log[i] : 4'hx, exp_res[i]);
    end

    // 3: fairness -- req0 held, req2 raised after gnt[0]
    gnt_log.delete();
    auto_drop[0] = 1'b0;
    req_data[7:0]   = 8'h40;
    req_data[23:16] = 8'h24;
    req[0] = 1'b1;
    for (int c = 0; c < 100 && gnt_log.size() < 1; c++) tick();
    req[2] = 1'b1;
    wait_rsp(3, 600);
    check("t3_first", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);
    check("t3_second", (gnt_log.size() > 1) ? gnt_log[1] : -1, 2);
    check("t3_third", (gnt_log.size() > 2) ? gnt_log[2] : -1, 0);

    // 5: reset in the middle of an operation
    do_reset();
    req_data[23:16] = 8'h31;
    req = 4'b0100;
    wait_rsp(1, 200);
    req_data[31:24] = 8'hC4;
    req[3] = 1'b1;
    for (int c = 0; c < 100 && !sq_st; c++) tick();
    check("t5_reached_issue", sq_st, 1);
    rst = 1'b1;
    #1;
    check("t5_sq_st", sq_st, 0);
    check("t5_busy", busy, 0);
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_gnt", gnt, 0);
    do_reset();
    req_data[7:0]   = 8'h19;
    req_data[31:24] = 8'h31;
    req = 4'b1001;
    wait_rsp(2, 300);
    check("t5_ptr_first", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);
    check("t5_ptr_second", (gnt_log.size() > 1) ? gnt_log[1] : -1, 3);

`ifdef SQRT_ARB_TIMEOUT_EN
    // 6: watchdog on a sqrt unit that never answers
    do_reset();
    stall = 1;
    req_data[7:0] = 8'h64;
    req = 4'b0001;
    wait_rsp(1, 300);
    stall = 0;
    check("t6_timeout_err", timeout_err, 1);
    req_data[15:8] = 8'h09;
    req[1] = 1'b1;
    wait_rsp(1, 300);
    check("t6_err_sticky", timeout_err, 1);
    do_reset();
    #1;
    check("t6_err_cleared", timeout_err, 0);
`endif

    // Randomized traffic
    do_reset();
    rand_mode = 1;
    repeat (3000) tick();
    rand_mode = 0;
    for (int c = 0; c < 1000 && (req != '0 || exp_q.size() != 0 || busy); c++) tick();
    check("drain_queue", exp_q.size(), 0);
    check("drain_busy", busy, 0);
    check("random_traffic_seen", (rsp_cnt > 50) ? 1 : 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
